dt_res_arbiter: RTL
===================

// Module: dt_res_arbiter
// PURPOSE
// - Shares the single-port result memory (res_* bus, 16384 x 8b) between two requesters:
//   port 0 = distance-transform engine, port 1 = host load/readout.
// - Round-robin arbitration, registered memory command, read-data return routed to the
//   issuing port; lock support for engine read-modify-write; bounded lock hold time.
// PARAMETERS
// - AW        14  result memory address width
// - DW        8   result memory data width
// - MAX_HOLD  16  max consecutive grants to a locked port while the other port requests (>=1)
// PORTS
// - clk          in   1   single clock, all logic on posedge
// - reset        in   1   asynchronous, active-low reset
// - req0/req1    in   1   request; held until gnt for that port
// - we0/we1      in   1   1=write, 0=read; stable while req high
// - lock0/lock1  in   1   keep grant on this port after the current grant
// - addr0/addr1  in   AW  request address
// - wdata0/1     in   DW  write data
// - gnt0/gnt1    out  1   one-cycle pulse: request accepted, command on res_* this cycle
// - rvalid0/1    out  1   one-cycle pulse: rdata0/1 holds read result
// - rdata0/1     out  DW  read data, held until next rvalid on that port
// - res_rd       out  1   memory read strobe
// - res_wr       out  1   memory write strobe
// - res_addr     out  AW  memory address
// - res_do       out  DW  memory write data
// - res_di       in   DW  memory read data, valid the cycle after res_rd
// - busy         out  1   command or read return in flight
// BEHAVIOUR
// - Reset: all outputs 0, last-winner pointer = port 1 (port 0 wins first tie), hold cnt 0.
// - Cycle t: req sampled, winner chosen. Cycle t+1: gntN=1, res_rd/res_wr/res_addr/res_do
//   driven from registered winner command. Read: cycle t+2 rvalidN=1, rdataN=res_di.
// - Requester deasserts or changes req in cycle t+1 (sees gnt); a req still high at t+1
//   clock edge is a new request. One command per cycle max; back-to-back throughput 1/cycle.
// - FSM: IDLE (no req) -> GRANT (issue winner) -> GRANT/IDLE per next-cycle reqs;
//   LOCKED entered when granted port had lockN=1; stays LOCKED while lockN=1.
// - Round-robin: both req -> port that did not win last; single req -> that port.
// - LOCKED: locked port has absolute priority; hold cnt increments per grant to it while
//   other port requests; at MAX_HOLD, next grant forced to other port, cnt cleared, lock kept.
// - Lock released when lockN=0 on a grant, or locked port idle with other port requesting.
// - res_rd and res_wr never both 1. res_addr/res_do hold last value when idle.
// - Addresses pass unmodified (no wrap/clip); AW-bit value used as is.
// - Read return routed by a 1-bit tag registered with the command; simultaneous rvalid on
//   both ports impossible. Write immediately followed by read to same addr returns new data.
// - Reset mid-operation: in-flight command/read return dropped, no rvalid issued.
// - busy = res_rd|res_wr|pending read return.
// CONFIGURATION
// - DT_ARB_FIXED_PRI_EN defined: port 0 always wins ties (no round-robin pointer);
//   lock and MAX_HOLD starvation rule still apply, so port 1 still served under lock.
// - Undefined: round-robin as above.
// TESTING
// - Reset, req0 read addr 16255, res_di=8'h07 -> gnt0 at t+1, res_rd=1 addr 16255, rvalid0
//   t+2 rdata0=8'h07.
// - req0 and req1 high every cycle, no lock -> grants alternate 0,1,0,1 (fixed-pri build:
//   0,0,0,...).
// - lock0=1 continuous, req0 and req1 held -> 16 gnt0 then one gnt1, repeating.
// - req1 write addr 0 data 8'h3C, then req0 read addr 0 next cycle -> res_wr then res_rd,
//   rdata0=8'h3C.
// - reset low the cycle after gnt0 for a read -> all outputs 0, no rvalid0.
// - Idle after traffic -> res_rd=res_wr=0, busy=0, res_addr holds last address.

Source files
------------

// File: rtl/dt_res_arbiter.sv
// rtl/dt_res_arbiter.sv - two-port round-robin arbiter for the single-port result memory
//
// Shares the 2**AW x DW result memory between port 0 (distance-transform engine) and
// port 1 (host load/readout). One command per cycle, issued the cycle after the request
// is sampled; read data returns on the issuing port two cycles after the request edge.
// A port may lock the arbiter for read-modify-write; the other port is still served
// after MAX_HOLD consecutive locked grants while it waits.
//
// Configuration macro: DT_ARB_FIXED_PRI_EN - port 0 always wins ties (no round-robin).
//
// Ports:
//   clk, reset               clock, asynchronous active-low reset
//   req/we/lock/addr/wdata   per-port request, direction, lock, address, write data
//   gnt0/gnt1                one-cycle grant pulse, command on res_* this cycle
//   rvalid0/1, rdata0/1      read return pulse and data (data held between returns)
//   res_rd/res_wr/res_addr/res_do/res_di   result memory bus
//   busy                     command or read return in flight
module dt_res_arbiter #(
    parameter int AW       = 14,
    parameter int DW       = 8,
    parameter int MAX_HOLD = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic          lock0,
    input  logic          lock1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic          res_rd,
    output logic          res_wr,
    output logic [AW-1:0] res_addr,
    output logic [DW-1:0] res_do,
    input  logic [DW-1:0] res_di,
    output logic          busy
);

    localparam int CW = $clog2(MAX_HOLD + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_GRANT  = 2'd1,
        S_LOCKED = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          lock_port_q, lock_port_d;
    logic [CW-1:0] hold_cnt_q, hold_cnt_d;
    logic          last_q;

    logic          gnt0_q, gnt1_q;
    logic          rd_q, wr_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] do_q;
    logic          tag_q;
    logic          rvalid0_q, rvalid1_q;
    logic [DW-1:0] rdata0_q, rdata1_q;

    logic          locked;
    logic          req_l, req_o;
    logic          win_valid, win, tie_win;
    logic          win_we, win_lock, win_other_req;

    assign locked = (state_q == S_LOCKED);
    assign req_l  = lock_port_q ? req1 : req0;
    assign req_o  = lock_port_q ? req0 : req1;

`ifdef DT_ARB_FIXED_PRI_EN
    assign tie_win = 1'b0;
`else
    // The port that did not win last time takes the tie.
    assign tie_win = ~last_q;
`endif

    always_comb begin
        win_valid     = 1'b0;
        win           = 1'b0;
        state_d       = state_q;
        lock_port_d   = lock_port_q;
        hold_cnt_d    = hold_cnt_q;

        if (locked && req_l) begin
            win_valid = 1'b1;
            // Starvation guard: hand one grant to the waiting port, lock stays.
            if (req_o && (hold_cnt_q >= CW'(MAX_HOLD))) begin
                win = ~lock_port_q;
            end else begin
                win = lock_port_q;
            end
        end else if (req0 || req1) begin
            win_valid = 1'b1;
            win       = (req0 && req1) ? tie_win : req1;
        end

        win_we        = win ? we1 : we0;
        win_lock      = win ? lock1 : lock0;
        win_other_req = win ? req0 : req1;

        if (!win_valid) begin
            state_d = locked ? S_LOCKED : S_IDLE;
        end else if (locked && (win != lock_port_q) && req_l) begin
            // Forced grant to the other port: keep the lock, restart the hold count.
            state_d    = S_LOCKED;
            hold_cnt_d = '0;
        end else if (win_lock) begin
            // Grant to the (new or continuing) lock owner; count only contested grants.
            state_d     = S_LOCKED;
            lock_port_d = win;
            hold_cnt_d  = ((locked && (win == lock_port_q)) ? hold_cnt_q : CW'(0))
                          + (win_other_req ? CW'(1) : CW'(0));
        end else begin
            // lockN low on a grant, or the lock owner went idle: lock released.
            state_d    = S_GRANT;
            hold_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            lock_port_q <= 1'b0;
            hold_cnt_q  <= '0;
            last_q      <= 1'b1;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            do_q        <= '0;
            tag_q       <= 1'b0;
            rvalid0_q   <= 1'b0;
            rvalid1_q   <= 1'b0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
        end else begin
            state_q     <= state_d;
            lock_port_q <= lock_port_d;
            hold_cnt_q  <= hold_cnt_d;
            gnt0_q      <= win_valid && !win;
            gnt1_q      <= win_valid && win;
            rd_q        <= win_valid && !win_we;
            wr_q        <= win_valid && win_we;
            if (win_valid) begin
                last_q <= win;
                tag_q  <= win;
                addr_q <= win ? addr1 : addr0;
                if (win_we) begin
                    do_q <= win ? wdata1 : wdata0;
                end
            end
            // Memory answers the cycle after res_rd; the tag steers it to one port only.
            rvalid0_q <= rd_q && !tag_q;
            rvalid1_q <= rd_q && tag_q;
            if (rvalid0_q) begin
                rdata0_q <= res_di;
            end
            if (rvalid1_q) begin
                rdata1_q <= res_di;
            end
        end
    end

    assign gnt0     = gnt0_q;
    assign gnt1     = gnt1_q;
    assign res_rd   = rd_q;
    assign res_wr   = wr_q;
    assign res_addr = addr_q;
    assign res_do   = do_q;
    assign rvalid0  = rvalid0_q;
    assign rvalid1  = rvalid1_q;
    // res_di is only valid during the return cycle, so pass it through then and hold after.
    assign rdata0   = rvalid0_q ? res_di : rdata0_q;
    assign rdata1   = rvalid1_q ? res_di : rdata1_q;
    assign busy     = rd_q || wr_q || rvalid0_q || rvalid1_q;

endmodule
